laser_interlock_sequencer: RTL and testbench

- Owns the laser power-enable and TA_shutdown outputs. Replaces direct decode from static_control and the combinational fail-OR.
- Sequences power-up: waits for stable pwr_good before releasing TA shutdown.
- Latches faults from limit_check, the power monitor and a host watchdog. Forces a minimum cooldown before re-arm.
- Sits between i2c_slave_top (control and kick bits) and the board pins. Runs on clk_div2 (25 MHz).

---
 rtl/laser_interlock_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_laser_interlock_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_interlock_sequencer.sv
// Laser supply / TA shutdown interlock: power-up sequencing, latched faults, watchdog and forced cooldown.
// Optional fault log (fault_count, first_fault) is built only when INTERLOCK_FAULT_LOG_EN is defined.
module laser_interlock_sequencer #(
    parameter int unsigned PWR_GOOD_CYCLES    = 25000,
    parameter int unsigned PWR_TIMEOUT_CYCLES = 250000,
    parameter int unsigned WDT_CYCLES         = 25000000,
    parameter int unsigned COOLDOWN_CYCLES    = 250000,
    parameter int unsigned CNT_W              = 25
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable_req,
    input  logic       error_check_en,
    input  logic       laser_ready,
    input  logic       pwr_good,
    input  logic       pulse_lower_fail,
    input  logic       pulse_upper_fail,
    input  logic       rate_fail,
    input  logic       current_fail,
    input  logic       clear_fail,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       laser_pwr_en,
    output logic       ta_shutdown,
    output logic       watchdog_timeout,
    output logic [2:0] seq_state,
    output logic [4:0] fault_cause,
    output logic [7:0] fault_count,
    output logic [4:0] first_fault
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_PWR_WAIT = 3'd1,
        S_RUN      = 3'd2,
        S_FAULT    = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GOOD_LAST    = CNT_W'(PWR_GOOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PWR_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LAST     = CNT_W'(WDT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);

    logic             r_pg_meta;
    logic             r_pg_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_stable_cnt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_wdt_cnt;
    logic             r_en;
    logic             r_shut;
    logic             r_wdt_to;
    logic [4:0]       r_cause;

    state_t           w_next;
    logic [4:0]       w_cause;
    logic [2:0]       w_limit_bits;
    logic             w_limit_any;
    logic             w_wdt_exp;
    logic [4:0]       w_run_bits;
    logic             w_clear_ok;

    assign w_limit_bits = {rate_fail, pulse_lower_fail | pulse_upper_fail, current_fail};
    assign w_limit_any  = |w_limit_bits;
    assign w_wdt_exp    = wdt_en && (r_wdt_cnt == WDT_LAST);
    assign w_run_bits   = {w_wdt_exp, ~r_pg_s, error_check_en ? w_limit_bits : 3'b000};
    assign w_clear_ok   = clear_fail && !w_limit_any && r_pg_s;

    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        case (r_state)
            S_OFF: begin
                if (enable_req && laser_ready) w_next = S_PWR_WAIT;
            end
            S_PWR_WAIT: begin
                // Timeout outranks both a host drop and a just-completed stable window.
                if (r_timer == TIMEOUT_LAST) begin
                    w_next  = S_FAULT;
                    w_cause = r_cause | 5'b01000;
                end else if (!enable_req) begin
                    w_next = S_COOLDOWN;
                end else if (r_pg_s && (r_stable_cnt == GOOD_LAST)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (|w_run_bits) begin
                    w_next  = S_FAULT;
                    w_cause = r_cause | w_run_bits;
                end else if (!enable_req) begin
                    w_next = S_COOLDOWN;
                end
            end
            S_FAULT: begin
                if (w_clear_ok) begin
                    w_next  = S_COOLDOWN;
                    w_cause = 5'b00000;
                end else begin
                    w_cause = r_cause | {2'b00, w_limit_bits};
                end
            end
            S_COOLDOWN: begin
                if (r_timer == COOL_LAST) w_next = S_OFF;
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pg_meta    <= 1'b0;
            r_pg_s       <= 1'b0;
            r_state      <= S_OFF;
            r_stable_cnt <= '0;
            r_timer      <= '0;
            r_wdt_cnt    <= '0;
            r_en         <= 1'b0;
            r_shut       <= 1'b1;
            r_wdt_to     <= 1'b0;
            r_cause      <= 5'b00000;
        end else begin
            r_pg_meta <= pwr_good;
            r_pg_s    <= r_pg_meta;
            r_state   <= w_next;
            r_cause   <= w_cause;
            r_en      <= (w_next == S_PWR_WAIT) || (w_next == S_RUN);
            r_shut    <= (w_next != S_RUN);

            // One timer serves both PWR_WAIT and COOLDOWN; any state change restarts it.
            if ((r_state == S_PWR_WAIT) && (w_next == S_PWR_WAIT)) begin
                r_timer      <= r_timer + CNT_W'(1);
                r_stable_cnt <= r_pg_s ? r_stable_cnt + CNT_W'(1) : '0;
            end else if ((r_state == S_COOLDOWN) && (w_next == S_COOLDOWN)) begin
                r_timer      <= r_timer + CNT_W'(1);
                r_stable_cnt <= '0;
            end else begin
                r_timer      <= '0;
                r_stable_cnt <= '0;
            end

            if ((r_state == S_RUN) && (w_next == S_RUN) && wdt_en && !wdt_kick)
                r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
            else
                r_wdt_cnt <= '0;

            if ((r_state == S_RUN) && w_wdt_exp)
                r_wdt_to <= 1'b1;
            else if ((r_state == S_FAULT) && w_clear_ok)
                r_wdt_to <= 1'b0;
        end
    end

    assign laser_pwr_en     = r_en;
    assign ta_shutdown      = r_shut;
    assign watchdog_timeout = r_wdt_to;
    assign seq_state        = r_state;
    assign fault_cause      = r_cause;

`ifdef INTERLOCK_FAULT_LOG_EN
    logic [7:0] r_fault_count;
    logic [4:0] r_first_fault;

    // A zero count means no FAULT entry yet, since the count saturates instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fault_count <= 8'd0;
            r_first_fault <= 5'b00000;
        end else if ((w_next == S_FAULT) && (r_state != S_FAULT)) begin
            if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
            if (r_fault_count == 8'd0) r_first_fault <= w_cause;
        end
    end

    assign fault_count = r_fault_count;
    assign first_fault = r_first_fault;
`else
    assign fault_count = 8'd0;
    assign first_fault = 5'b00000;
`endif

endmodule

// File: tb/tb_laser_interlock_sequencer.sv
// Directed bench for laser_interlock_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_laser_interlock_sequencer;

    logic       clk;
    logic       rstn;
    logic       enable_req;
    logic       error_check_en;
    logic       laser_ready;
    logic       pwr_good;
    logic       pulse_lower_fail;
    logic       pulse_upper_fail;
    logic       rate_fail;
    logic       current_fail;
    logic       clear_fail;
    logic       wdt_en;
    logic       wdt_kick;
    logic       laser_pwr_en;
    logic       ta_shutdown;
    logic       watchdog_timeout;
    logic [2:0] seq_state;
    logic [4:0] fault_cause;
    logic [7:0] fault_count;
    logic [4:0] first_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    laser_interlock_sequencer #(
        .PWR_GOOD_CYCLES   (8),
        .PWR_TIMEOUT_CYCLES(40),
        .WDT_CYCLES        (64),
        .COOLDOWN_CYCLES   (16),
        .CNT_W             (25)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .enable_req      (enable_req),
        .error_check_en  (error_check_en),
        .laser_ready     (laser_ready),
        .pwr_good        (pwr_good),
        .pulse_lower_fail(pulse_lower_fail),
        .pulse_upper_fail(pulse_upper_fail),
        .rate_fail       (rate_fail),
        .current_fail    (current_fail),
        .clear_fail      (clear_fail),
        .wdt_en          (wdt_en),
        .wdt_kick        (wdt_kick),
        .laser_pwr_en    (laser_pwr_en),
        .ta_shutdown     (ta_shutdown),
        .watchdog_timeout(watchdog_timeout),
        .seq_state       (seq_state),
        .fault_cause     (fault_cause),
        .fault_count     (fault_count),
        .first_fault     (first_fault)
    );

    // Clock and time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL time_limit: got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "time limit");
    end

    typedef struct {
        logic       en_req;
        logic       lready;
        logic       pg;
        logic       ec;
        logic       lower;
        logic       upper;
        logic       rate;
        logic       cur;
        logic       clr;
        int         cyc;
        logic [2:0] st;
        logic       en;
        logic       shut;
        logic [4:0] cause;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic en_req, input logic lready, input logic pg, input logic ec,
                                input logic lower, input logic upper, input logic rate, input logic cur,
                                input logic clr, input int cyc, input logic [2:0] st, input logic en,
                                input logic shut, input logic [4:0] cause);
        vec_t v;
        v.en_req = en_req; v.lready = lready; v.pg = pg; v.ec = ec;
        v.lower = lower; v.upper = upper; v.rate = rate; v.cur = cur; v.clr = clr;
        v.cyc = cyc; v.st = st; v.en = en; v.shut = shut; v.cause = cause;
        return v;
    endfunction

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_all_fails();
        pulse_lower_fail = 1'b0;
        pulse_upper_fail = 1'b0;
        rate_fail        = 1'b0;
        current_fail     = 1'b0;
        clear_fail       = 1'b0;
    endtask

    task automatic go_run(input string name);
        int waited;
        clear_all_fails();
        enable_req  = 1'b1;
        laser_ready = 1'b1;
        pwr_good    = 1'b1;
        waited      = 0;
        while (seq_state !== 3'd2 && waited < 200) begin
            tick(1);
            waited++;
        end
        check(name, {29'd0, seq_state}, 32'd2);
    endtask

    task automatic clear_fault(input string name);
        clear_all_fails();
        pwr_good = 1'b1;
        tick(3);
        clear_fail = 1'b1;
        tick(1);
        clear_fail = 1'b0;
        check({name, "_state"}, {29'd0, seq_state}, 32'd4);
        check({name, "_cause"}, {27'd0, fault_cause}, 32'd0);
    endtask

    initial begin
        rstn           = 1'b0;
        enable_req     = 1'b0;
        error_check_en = 1'b0;
        laser_ready    = 1'b0;
        pwr_good       = 1'b0;
        wdt_en         = 1'b0;
        wdt_kick       = 1'b0;
        clear_all_fails();

        //               en lr pg ec lo up rt cu cl cyc st en sh cause
        vecs[0]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 1, 5'b00000);
        vecs[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  8, 1, 1, 1, 5'b00000);
        vecs[2]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 2, 1, 0, 5'b00000);
        vecs[3]  = mk(1, 1, 1, 1, 0, 1, 1, 0, 0,  1, 3, 0, 1, 5'b00110);
        vecs[4]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 3, 0, 1, 5'b00110);
        vecs[5]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 1,  1, 4, 0, 1, 5'b00000);
        vecs[6]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 15, 4, 0, 1, 5'b00000);
        vecs[7]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 5'b00000);
        vecs[8]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 1, 5'b00000);
        vecs[9]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  7, 1, 1, 1, 5'b00000);
        vecs[10] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 2, 1, 0, 5'b00000);
        vecs[11] = mk(1, 1, 1, 0, 0, 1, 1, 0, 0,  1, 2, 1, 0, 5'b00000);
        vecs[12] = mk(1, 1, 1, 0, 1, 0, 0, 1, 0,  1, 2, 1, 0, 5'b00000);
        vecs[13] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  2, 2, 1, 0, 5'b00000);
        vecs[14] = mk(1, 1, 1, 1, 0, 0, 0, 1, 0,  1, 3, 0, 1, 5'b00001);
        vecs[15] = mk(1, 1, 1, 1, 0, 0, 0, 1, 1,  1, 3, 0, 1, 5'b00001);
        vecs[16] = mk(1, 1, 1, 0, 1, 0, 0, 0, 1,  1, 3, 0, 1, 5'b00011);
        vecs[17] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 3, 0, 1, 5'b00011);
        vecs[18] = mk(1, 1, 1, 1, 0, 0, 0, 0, 1,  1, 4, 0, 1, 5'b00000);
        vecs[19] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 15, 4, 0, 1, 5'b00000);
        vecs[20] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 5'b00000);
        vecs[21] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 1, 5'b00000);
        vecs[22] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0,  1, 4, 0, 1, 5'b00000);
        vecs[23] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 16, 0, 0, 1, 5'b00000);
        vecs[24] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 5'b00000);

        // Reset values
        tick(3);
        check("rst_en",    {31'd0, laser_pwr_en},     32'd0);
        check("rst_shut",  {31'd0, ta_shutdown},      32'd1);
        check("rst_state", {29'd0, seq_state},        32'd0);
        check("rst_cause", {27'd0, fault_cause},      32'd0);
        check("rst_wdt",   {31'd0, watchdog_timeout}, 32'd0);
        check("rst_count", {24'd0, fault_count},      32'd0);
        check("rst_first", {27'd0, first_fault},      32'd0);
        rstn = 1'b1;

        // Power-up, limit faults, clear and cooldown from the table
        for (int i = 0; i < 25; i++) begin
            enable_req       = vecs[i].en_req;
            laser_ready      = vecs[i].lready;
            pwr_good         = vecs[i].pg;
            error_check_en   = vecs[i].ec;
            pulse_lower_fail = vecs[i].lower;
            pulse_upper_fail = vecs[i].upper;
            rate_fail        = vecs[i].rate;
            current_fail     = vecs[i].cur;
            clear_fail       = vecs[i].clr;
            tick(vecs[i].cyc);
            check($sformatf("vec%0d_state", i), {29'd0, seq_state},   {29'd0, vecs[i].st});
            check($sformatf("vec%0d_en", i),    {31'd0, laser_pwr_en}, {31'd0, vecs[i].en});
            check($sformatf("vec%0d_shut", i),  {31'd0, ta_shutdown},  {31'd0, vecs[i].shut});
            check($sformatf("vec%0d_cause", i), {27'd0, fault_cause},  {27'd0, vecs[i].cause});
            check($sformatf("vec%0d_wdt", i),   {31'd0, watchdog_timeout}, 32'd0);
        end
        clear_all_fails();
        error_check_en = 1'b1;

        // Glitch on pwr_good at stable count 5 restarts the stable window
        laser_ready = 1'b1;
        pwr_good    = 1'b1;
        tick(1);
        check("glitch_entry", {29'd0, seq_state}, 32'd1);
        tick(3);
        pwr_good = 1'b0;
        tick(1);
        pwr_good = 1'b1;
        tick(9);
        check("glitch_still_wait", {29'd0, seq_state}, 32'd1);
        check("glitch_shut",       {31'd0, ta_shutdown}, 32'd1);
        tick(1);
        check("glitch_run", {29'd0, seq_state}, 32'd2);
        check("glitch_shut_low", {31'd0, ta_shutdown}, 32'd0);

        // Power-good timeout while pwr_good toggles every 4 cycles
        enable_req = 1'b0;
        tick(1);
        check("drop_cooldown", {29'd0, seq_state}, 32'd4);
        tick(16);
        check("drop_off", {29'd0, seq_state}, 32'd0);
        enable_req = 1'b1;
        tick(1);
        check("tmo_entry", {29'd0, seq_state}, 32'd1);
        for (int i = 0; i < 39; i++) begin
            pwr_good = ((i / 4) % 2) == 1;
            tick(1);
        end
        check("tmo_wait_39", {29'd0, seq_state}, 32'd1);
        tick(1);
        check("tmo_fault", {29'd0, seq_state},   32'd3);
        check("tmo_cause", {27'd0, fault_cause}, 32'h08);
        check("tmo_en",    {31'd0, laser_pwr_en}, 32'd0);
        clear_fault("tmo_clear");

        // Watchdog: periodic kicks hold RUN, missing kicks expire it
        go_run("wdt_run");
        wdt_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(49);
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            check($sformatf("wdt_kick%0d_state", k), {29'd0, seq_state}, 32'd2);
        end
        tick(63);
        check("wdt_pre_state", {29'd0, seq_state},        32'd2);
        check("wdt_pre_flag",  {31'd0, watchdog_timeout}, 32'd0);
        tick(1);
        check("wdt_exp_state", {29'd0, seq_state},        32'd3);
        check("wdt_exp_flag",  {31'd0, watchdog_timeout}, 32'd1);
        check("wdt_exp_cause", {27'd0, fault_cause},      32'h10);
        check("wdt_exp_shut",  {31'd0, ta_shutdown},      32'd1);
        wdt_en = 1'b0;
        clear_fault("wdt_clear");
        check("wdt_flag_clr", {31'd0, watchdog_timeout}, 32'd0);

        // Asynchronous reset in RUN, then three faults for the log
        go_run("arst_run");
        #3;
        rstn = 1'b0;
        #1;
        check("arst_en",    {31'd0, laser_pwr_en}, 32'd0);
        check("arst_shut",  {31'd0, ta_shutdown},  32'd1);
        check("arst_state", {29'd0, seq_state},    32'd0);
        check("arst_count", {24'd0, fault_count},  32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        go_run("log_run1");
        current_fail = 1'b1;
        tick(1);
        current_fail = 1'b0;
        check("log_f1_cause", {27'd0, fault_cause}, 32'h01);
        clear_fault("log_clr1");
        go_run("log_run2");
        rate_fail = 1'b1;
        tick(1);
        rate_fail = 1'b0;
        check("log_f2_cause", {27'd0, fault_cause}, 32'h04);
        clear_fault("log_clr2");
        go_run("log_run3");
        pwr_good = 1'b0;
        tick(2);
        check("log_pwr_lag", {29'd0, seq_state}, 32'd2);
        tick(1);
        check("log_f3_state", {29'd0, seq_state},   32'd3);
        check("log_f3_cause", {27'd0, fault_cause}, 32'h08);
`ifdef INTERLOCK_FAULT_LOG_EN
        check("log_count", {24'd0, fault_count}, 32'd3);
        check("log_first", {27'd0, first_fault}, 32'h01);
`else
        check("log_count", {24'd0, fault_count}, 32'd0);
        check("log_first", {27'd0, first_fault}, 32'h00);
`endif
        clear_fault("log_clr3");

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
